pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline. It sequences the ID stage and the IF/ID and ID/EX registers.
- Detects RAW hazards against EX/MEM/WB, produces ID-stage forward selects, and resolves EX-stage redirects.
- Runs a trap FSM that drains the pipeline on ECALL/EBREAK and holds it halted until the host resumes.
- Sits beside the ID stage; all outputs drive the IF, IF/ID and ID/EX enables and flushes.

Parameters:
- DRAIN_CYCLES, 3, cycles held in DRAIN so the instructions older than the trap retire through EX/MEM/WB.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- id_rs1_addr  in  5  rs1 of instruction in ID
- id_rs2_addr  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_is_ecall  in  1  ECALL decoded in ID
- id_is_ebreak  in  1  EBREAK decoded in ID
- ex_rd_addr  in  5  rd of instruction in EX
- ex_reg_write  in  1  EX instruction writes rd
- mem_rd_addr  in  5  rd of instruction in MEM
- mem_reg_write  in  1  MEM instruction writes rd
- mem_mem_read  in  1  MEM instruction is a load
- wb_rd_addr  in  5  rd of instruction in WB
- wb_reg_write  in  1  WB instruction writes rd
- ex_redirect  in  1  branch taken or jump resolved in EX
- dmem_busy  in  1  data memory wait
- resume  in  1  host resume pulse
- forward_a_sel  out  2  rs1 forward select: 10 MEM, 01 WB, 00 regfile
- forward_b_sel  out  2  rs2 forward select, same encoding
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  bubble IF/ID
- idex_flush  out  1  bubble ID/EX
- pipe_freeze  out  1  hold EX/MEM and MEM/WB
- halted  out  1  registered; FSM in HALT
- trap_cause  out  2  registered; 01 ECALL, 10 EBREAK, 00 none
- stall_cnt  out  CNT_W  load-use/RAW stall cycles, wraps

Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset:
  - state=RUN, halted=0, trap_cause=00, stall_cnt=0, drain counter=0.
  - The combinational outputs are 0 given idle inputs.
- Match rule: a source matches a stage when its use flag=1, stage reg_write=1, stage rd==src, and rd!=0. x0 never matches.
- Forwarding (combinational, per source):
  - MEM match with mem_mem_read=0 -> 10.
  - Else WB match -> 01.
  - Else 00.
  - MEM takes priority over WB.
- RAW stall: raw = EX match, or (MEM match and mem_mem_read=1), on either source. Load data is not forwardable from MEM.
  - Response: pc_stall=1, ifid_stall=1, idex_flush=1.
  - Latency: 1 cycle for an EX ALU producer, 2 cycles for a load in EX.
- Priority per cycle, highest first: dmem_busy > ex_redirect > raw > trap entry.
  - dmem_busy=1: pc_stall, ifid_stall and pipe_freeze=1; no flushes. The drain counter and stall_cnt hold.
  - ex_redirect=1: ifid_flush=1 and idex_flush=1. RAW stall and trap entry are suppressed, because the ID instruction is on the wrong path.
- stall_cnt: +1 each cycle raw causes a stall (not counted under dmem_busy or redirect). Wraps at 2^CNT_W.
- FSM states and transitions:
  - RUN -> DRAIN: when (id_is_ecall|id_is_ebreak) and no higher-priority event.
    - Latch trap_cause; EBREAK wins if both are set.
    - Load the drain counter with DRAIN_CYCLES-1.
    - Same cycle: pc_stall=1, ifid_stall=1, idex_flush=1. The trap instruction never enters EX.
  - DRAIN: pc_stall=1, ifid_stall=1, idex_flush=1 every cycle. The counter decrements except under dmem_busy; at 0 -> HALT.
  - HALT: halted=1; stalls held as in DRAIN; resume is ignored in RUN and DRAIN.
  - HALT -> RUN: on resume=1. That cycle pc_stall=0, ifid_stall=0, no flush, so IF/ID loads trap PC+4 and overwrites the trap instruction. halted and trap_cause clear next edge.
- Async reset mid-DRAIN or mid-HALT returns to RUN immediately with reset values.
- halted and trap_cause are flops; everything else is combinational from state and inputs.

Decomposition:
- defines.vh holds:
  - FWD_NONE/FWD_WB/FWD_MEM (2'b00/01/10)
  - TRAP_NONE/TRAP_ECALL/TRAP_EBREAK
  - state encodings ST_RUN/ST_DRAIN/ST_HALT
- One combinational sub-module, fwd_hazard_cmp: match, forwarding select and raw detect, instantiated once for both sources.
- The FSM, priority mux and counter stay in the top module.

Test Plan:
- MEM: x5 reg_write, no load; WB: x5; ID rs1=x5 -> forward_a_sel=10, no stall.
- EX: lw x7 (reg_write=1), ID uses rs2=x7 -> stall 1 cycle; next cycle the load is in MEM with mem_mem_read=1 -> stall again; then WB forward_b_sel=01. stall_cnt=2.
- ex_redirect=1 same cycle as an EX RAW match and id_is_ecall=1 -> ifid_flush=1, idex_flush=1, no stall, state stays RUN, stall_cnt unchanged.
- id_is_ebreak=1 in RUN -> DRAIN 3 cycles (DRAIN_CYCLES=3), then halted=1 with trap_cause=10. resume pulse -> pc_stall=0 that cycle, halted=0 next cycle.
- dmem_busy=1 for 4 cycles during DRAIN -> pipe_freeze=1, the drain counter holds, HALT is reached 4 cycles later than nominal.
- rst_n asserted while HALT -> halted=0, trap_cause=00, stall_cnt=0 asynchronously; rd=0 with reg_write in MEM never forwards.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Latency: n/a (types only); backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_NONE    = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam logic [1:0] TRAP_NONE   = 2'b00;
    localparam logic [1:0] TRAP_ECALL  = 2'b01;
    localparam logic [1:0] TRAP_EBREAK = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic rd_match(input logic       src_used,
                                      input logic [4:0] src_addr,
                                      input logic       reg_write,
                                      input logic [4:0] rd_addr);
        return src_used && reg_write && (rd_addr == src_addr) && (rd_addr != 5'd0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_hazard_cmp.sv
// Per-source RAW compare: forward select against MEM/WB and stall request against EX/MEM-load.
// Latency: combinational; backpressure: none, pure function of its inputs.
module fwd_hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic       src_used,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_reg_write,
    input  logic [4:0] mem_rd_addr,
    input  logic       mem_reg_write,
    input  logic       mem_mem_read,
    input  logic [4:0] wb_rd_addr,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_sel,
    output logic       raw
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit  = rd_match(src_used, src_addr, ex_reg_write,  ex_rd_addr);
        mem_hit = rd_match(src_used, src_addr, mem_reg_write, mem_rd_addr);
        wb_hit  = rd_match(src_used, src_addr, wb_reg_write,  wb_rd_addr);

        // Load data only exists after MEM, so a MEM-stage load falls through to WB or stalls.
        fwd_sel = FWD_NONE;
        if (mem_hit && !mem_mem_read) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end

        raw = ex_hit || (mem_hit && mem_mem_read);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with trap drain/halt FSM.
// Latency: controls are combinational, halted/trap_cause registered; dmem_busy freezes everything.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_ecall,
    input  logic             id_is_ebreak,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_reg_write,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    input  logic             resume,
    output logic [1:0]       forward_a_sel,
    output logic [1:0]       forward_b_sel,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    state_t            state, state_nxt;
    logic [DCNT_W-1:0] drain_cnt, drain_nxt;
    logic [1:0]        cause_nxt;
    logic              raw_a, raw_b, raw;
    logic              stall_inc;

    fwd_hazard_cmp u_cmp_a (
        .src_addr      (id_rs1_addr),
        .src_used      (id_uses_rs1),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (forward_a_sel),
        .raw           (raw_a)
    );

    fwd_hazard_cmp u_cmp_b (
        .src_addr      (id_rs2_addr),
        .src_used      (id_uses_rs2),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (forward_b_sel),
        .raw           (raw_b)
    );

    assign raw = raw_a || raw_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt  <= '0;
            halted     <= 1'b0;
            trap_cause <= TRAP_NONE;
            stall_cnt  <= '0;
        end else begin
            drain_cnt  <= drain_nxt;
            halted     <= (state_nxt == ST_HALT);
            trap_cause <= cause_nxt;
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        cause_nxt   = trap_cause;
        stall_inc   = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;

        if (dmem_busy) begin
            // Whole pipe waits on memory; FSM progress and stall accounting pause too.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            pipe_freeze = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (raw) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (id_is_ecall || id_is_ebreak) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        state_nxt  = ST_DRAIN;
                        drain_nxt  = DRAIN_LOAD;
                        cause_nxt  = id_is_ebreak ? TRAP_EBREAK : TRAP_ECALL;
                    end
                end
                ST_DRAIN: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    if (drain_cnt == '0) begin
                        state_nxt = ST_HALT;
                    end else begin
                        drain_nxt = drain_cnt - DCNT_W'(1);
                    end
                end
                ST_HALT: begin
                    // On resume IF/ID reloads with trap PC+4, replacing the held trap instruction.
                    if (resume) begin
                        state_nxt = ST_RUN;
                        cause_nxt = TRAP_NONE;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: forwarding vector table, hand-written trap/stall sequences, random run vs reference model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int P_RUN = 0, P_DRAIN = 1, P_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic        id_uses_rs1, id_uses_rs2, id_is_ecall, id_is_ebreak;
    logic        ex_reg_write, mem_reg_write, mem_mem_read, wb_reg_write;
    logic        ex_redirect, dmem_busy, resume;
    logic [1:0]  forward_a_sel, forward_b_sel, trap_cause;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, halted;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: pipeline phase, DRAIN cycles still to go, latched cause, stall total.
    int          m_phase;
    int          m_left;
    logic [1:0]  m_cause;
    logic [31:0] m_cnt;

    typedef struct {
        logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
        logic [4:0] exrd; logic exwe;
        logic [4:0] memrd; logic memwe; logic memld;
        logic [4:0] wbrd; logic wbwe;
        logic [1:0] efa; logic [1:0] efb; logic estall;
    } vec_t;

    vec_t vecs[12];

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_is_ecall(id_is_ecall), .id_is_ebreak(id_is_ebreak),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy), .resume(resume),
        .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
        .trap_cause(trap_cause), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mt(input logic u, input logic [4:0] src, input logic we, input logic [4:0] rd);
        return u && we && (rd == src) && (rd != 5'd0);
    endfunction

    task automatic set_idle();
        {id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
        {id_uses_rs1, id_uses_rs2, id_is_ecall, id_is_ebreak} = '0;
        {ex_reg_write, mem_reg_write, mem_mem_read, wb_reg_write} = '0;
        {ex_redirect, dmem_busy, resume} = '0;
    endtask

    task automatic model_reset();
        m_phase = P_RUN; m_left = 0; m_cause = 2'b00; m_cnt = 32'd0;
    endtask

    // Called just after a falling edge with inputs applied; compares, then advances one clock.
    task automatic cycle();
        logic       ma, mb, wa, wb, raw;
        logic [1:0] efa, efb, ncause;
        logic       ep, eff, edf, ez;
        int         nphase, nleft;
        logic [31:0] ncnt;
        ma  = mt(id_uses_rs1, id_rs1_addr, mem_reg_write, mem_rd_addr);
        mb  = mt(id_uses_rs2, id_rs2_addr, mem_reg_write, mem_rd_addr);
        wa  = mt(id_uses_rs1, id_rs1_addr, wb_reg_write, wb_rd_addr);
        wb  = mt(id_uses_rs2, id_rs2_addr, wb_reg_write, wb_rd_addr);
        efa = (ma && !mem_mem_read) ? 2'b10 : (wa ? 2'b01 : 2'b00);
        efb = (mb && !mem_mem_read) ? 2'b10 : (wb ? 2'b01 : 2'b00);
        raw = mt(id_uses_rs1, id_rs1_addr, ex_reg_write, ex_rd_addr)
            || mt(id_uses_rs2, id_rs2_addr, ex_reg_write, ex_rd_addr)
            || (mem_mem_read && (ma || mb));
        ep = 0; eff = 0; edf = 0; ez = 0;
        nphase = m_phase; nleft = m_left; ncause = m_cause; ncnt = m_cnt;
        if (dmem_busy) begin
            ep = 1; ez = 1;
        end else if (m_phase == P_RUN) begin
            if (ex_redirect) begin
                eff = 1; edf = 1;
            end else if (raw) begin
                ep = 1; edf = 1; ncnt = m_cnt + 32'd1;
            end else if (id_is_ecall || id_is_ebreak) begin
                ep = 1; edf = 1; nphase = P_DRAIN; nleft = DRAIN;
                ncause = id_is_ebreak ? 2'b10 : 2'b01;
            end
        end else if (m_phase == P_DRAIN) begin
            ep = 1; edf = 1; nleft = m_left - 1;
            if (nleft == 0) nphase = P_HALT;
        end else begin
            if (resume) begin
                nphase = P_RUN; ncause = 2'b00;
            end else begin
                ep = 1; edf = 1;
            end
        end
        #1;
        check("outputs",
              {forward_a_sel, forward_b_sel, pc_stall, ifid_stall, ifid_flush, idex_flush,
               pipe_freeze, halted, trap_cause},
              {efa, efb, ep, ep, eff, edf, ez, (m_phase == P_HALT), m_cause});
        check("stall_cnt", stall_cnt, m_cnt);
        @(posedge clk);
        m_phase = nphase; m_left = nleft; m_cause = ncause; m_cnt = ncnt;
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] cnt0;

        //         rs1    rs2   u1 u2  exrd  exwe memrd  mwe  mld  wbrd  wwe  efa    efb  stall
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 2'b00, 0};
        vecs[1]  = '{5'd5, 5'd0, 1, 0, 5'd0, 0, 5'd5, 1, 0, 5'd5, 1, 2'b10, 2'b00, 0};
        vecs[2]  = '{5'd5, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd5, 1, 2'b01, 2'b00, 0};
        vecs[3]  = '{5'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 1, 0, 5'd0, 1, 2'b00, 2'b00, 0};
        vecs[4]  = '{5'd0, 5'd7, 0, 1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 2'b00, 2'b00, 1};
        vecs[5]  = '{5'd0, 5'd7, 0, 1, 5'd0, 0, 5'd7, 1, 1, 5'd0, 0, 2'b00, 2'b00, 1};
        vecs[6]  = '{5'd0, 5'd7, 0, 1, 5'd0, 0, 5'd7, 1, 1, 5'd7, 1, 2'b00, 2'b01, 1};
        vecs[7]  = '{5'd6, 5'd0, 0, 0, 5'd6, 1, 5'd6, 1, 0, 5'd6, 1, 2'b00, 2'b00, 0};
        vecs[8]  = '{5'd3, 5'd3, 1, 1, 5'd0, 0, 5'd3, 1, 0, 5'd0, 0, 2'b10, 2'b10, 0};
        vecs[9]  = '{5'd4, 5'd0, 1, 0, 5'd4, 0, 5'd0, 0, 0, 5'd0, 0, 2'b00, 2'b00, 0};
        vecs[10] = '{5'd9, 5'd9, 1, 1, 5'd0, 0, 5'd9, 0, 0, 5'd9, 1, 2'b01, 2'b01, 0};
        vecs[11] = '{5'd0, 5'd2, 1, 1, 5'd0, 1, 5'd2, 1, 0, 5'd1, 1, 2'b00, 2'b10, 0};

        set_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_regs", {halted, trap_cause, stall_cnt}, 35'd0);
        check("reset_comb", {forward_a_sel, forward_b_sel, pc_stall, ifid_stall, ifid_flush,
                             idex_flush, pipe_freeze}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 12; i++) begin
            {id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2} =
                {vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2};
            {ex_rd_addr, ex_reg_write} = {vecs[i].exrd, vecs[i].exwe};
            {mem_rd_addr, mem_reg_write, mem_mem_read} = {vecs[i].memrd, vecs[i].memwe, vecs[i].memld};
            {wb_rd_addr, wb_reg_write} = {vecs[i].wbrd, vecs[i].wbwe};
            #1;
            check($sformatf("vec%0d", i), {forward_a_sel, forward_b_sel, pc_stall},
                  {vecs[i].efa, vecs[i].efb, vecs[i].estall});
            cycle();
        end

        // Load-use: load in EX, then in MEM, then forwarded from WB.
        set_idle();
        cnt0 = m_cnt;
        id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1;
        ex_rd_addr = 5'd7; ex_reg_write = 1'b1;
        #1; check("lu_ex_stall", {pc_stall, ifid_stall, idex_flush}, 3'b111);
        cycle();
        ex_reg_write = 1'b0; mem_rd_addr = 5'd7; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        #1; check("lu_mem_stall", {pc_stall, forward_b_sel}, 3'b100);
        cycle();
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; wb_rd_addr = 5'd7; wb_reg_write = 1'b1;
        #1; check("lu_wb_fwd", {pc_stall, forward_b_sel}, 3'b001);
        cycle();
        check("lu_stall_cnt", stall_cnt, cnt0 + 32'd2);

        // Redirect overrides both RAW and trap entry.
        set_idle();
        cnt0 = m_cnt;
        id_rs1_addr = 5'd4; id_uses_rs1 = 1'b1; ex_rd_addr = 5'd4; ex_reg_write = 1'b1;
        id_is_ecall = 1'b1; ex_redirect = 1'b1;
        #1; check("redir_out", {ifid_flush, idex_flush, pc_stall, ifid_stall}, 4'b1100);
        cycle();
        set_idle();
        #1; check("redir_still_run", {pc_stall, halted}, 2'b00);
        check("redir_cnt", stall_cnt, cnt0);
        cycle();

        // EBREAK: three DRAIN cycles then HALT; resume releases the same cycle.
        id_is_ebreak = 1'b1; id_is_ecall = 1'b1;
        #1; check("ebreak_entry", {pc_stall, ifid_stall, idex_flush}, 3'b111);
        cycle();
        set_idle();
        resume = 1'b1;
        n = 0;
        while (!halted && n < 20) begin
            cycle();
            n++;
        end
        resume = 1'b0;
        check("ebreak_drain_len", n, DRAIN);
        check("ebreak_cause", {halted, trap_cause}, 3'b110);
        cycle();
        resume = 1'b1;
        #1; check("resume_release", {pc_stall, ifid_stall, ifid_flush, idex_flush}, 4'b0000);
        cycle();
        resume = 1'b0;
        check("resume_clear", {halted, trap_cause}, 3'b000);

        // ECALL with dmem_busy stretching DRAIN by four cycles.
        id_is_ecall = 1'b1;
        cycle();
        set_idle();
        n = 0;
        while (!halted && n < 20) begin
            dmem_busy = (n >= 1 && n <= 4);
            if (dmem_busy) begin
                #1; check("busy_freeze", {pipe_freeze, idex_flush, pc_stall}, 3'b101);
            end
            cycle();
            n++;
        end
        dmem_busy = 1'b0;
        check("busy_drain_len", n, DRAIN + 4);
        check("ecall_cause", {halted, trap_cause}, 3'b101);

        // Asynchronous reset while halted.
        #2 rst_n = 1'b0;
        #1;
        check("arst_regs", {halted, trap_cause, stall_cnt}, 35'd0);
        check("arst_comb", {pc_stall, ifid_stall, idex_flush}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mem_rd_addr = 5'd0; mem_reg_write = 1'b1; id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
        #1; check("x0_no_fwd", forward_a_sel, 2'b00);
        cycle();

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            id_rs1_addr   = 5'($urandom_range(0, 3));
            id_rs2_addr   = 5'($urandom_range(0, 3));
            ex_rd_addr    = 5'($urandom_range(0, 3));
            mem_rd_addr   = 5'($urandom_range(0, 3));
            wb_rd_addr    = 5'($urandom_range(0, 3));
            id_uses_rs1   = 1'($urandom_range(0, 1));
            id_uses_rs2   = 1'($urandom_range(0, 1));
            ex_reg_write  = ($urandom_range(0, 3) == 0);
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_mem_read  = ($urandom_range(0, 2) == 0);
            wb_reg_write  = 1'($urandom_range(0, 1));
            id_is_ecall   = ($urandom_range(0, 7) == 0);
            id_is_ebreak  = ($urandom_range(0, 11) == 0);
            ex_redirect   = ($urandom_range(0, 7) == 0);
            dmem_busy     = ($urandom_range(0, 7) == 0);
            resume        = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
